// File: rtl/op_issue_ctrl.sv
`default_nettype none
// ============================================================================
// op_issue_ctrl : instruction decode/issue controller, stalls fetch on MUL/DIV/LOA/lookup
// Option macro OP_ISSUE_ILLEGAL_TRAP_EN : opcode 4'b1111 halts. Revision 1.0
// ============================================================================
module op_issue_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8,
    parameter int MEM_LAT = 2
) (
    input  logic       CLK,
    input  logic       Reset_n,
    input  logic [8:0] inst,
    input  logic       inst_valid,
    output logic       inst_ready,
    output logic [3:0] op,
    output logic [4:0] field,
    output logic       ctl_valid,
    output logic       alu_start,
    output logic       mem_re,
    output logic       mem_we,
    output logic       lut_re,
    output logic       reg_we,
    output logic       busy,
    output logic       halted,
    output logic       illegal
);

    localparam int CW = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;

    localparam logic [CW-1:0] MUL_LD = CW'(MUL_LAT - 2);
    localparam logic [CW-1:0] DIV_LD = CW'(DIV_LAT - 2);
    localparam logic [CW-1:0] MEM_LD = CW'(MEM_LAT - 2);

    localparam logic [3:0] OP_DIV  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_LOA  = 4'd11;
    localparam logic [3:0] OP_STR  = 4'd12;
    localparam logic [3:0] OP_DONE = 4'd13;
    localparam logic [3:0] OP_LKP  = 4'd14;
    localparam logic [3:0] OP_ILL  = 4'd15;

    // Every latency must be >= 2 and its reload value must fit the counter.
    if (MUL_LAT < 2 || DIV_LAT < 2 || MEM_LAT < 2 ||
        (MUL_LAT - 2) >= (1 << CW) || (MEM_LAT - 2) >= (1 << CW)) begin : g_bad_lat
        $error("op_issue_ctrl: latency parameters out of range");
    end

    typedef enum logic [1:0] {
        ST_DECODE = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      op_q, op_d;
    logic [4:0]      field_q, field_d;
    logic            ctl_valid_q, ctl_valid_d;
    logic            alu_start_q, alu_start_d;
    logic            mem_re_q, mem_re_d;
    logic            mem_we_q, mem_we_d;
    logic            lut_re_q, lut_re_d;
    logic            reg_we_q, reg_we_d;
    logic            busy_q, busy_d;
    logic            halted_q, halted_d;
    logic            illegal_q, illegal_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        field_d     = field_q;
        ctl_valid_d = 1'b0;
        alu_start_d = 1'b0;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        lut_re_d    = 1'b0;
        reg_we_d    = 1'b0;
        busy_d      = 1'b0;
        halted_d    = halted_q;
        illegal_d   = illegal_q;

        case (state_q)
            ST_DECODE: begin
                if (inst_valid) begin
                    op_d        = inst[8:5];
                    field_d     = inst[4:0];
                    ctl_valid_d = 1'b1;
                    case (inst[8:5])
                        OP_MUL: begin
                            alu_start_d = 1'b1;
                            cnt_d       = MUL_LD;
                            busy_d      = 1'b1;
                            state_d     = ST_WAIT;
                        end
                        OP_DIV: begin
                            alu_start_d = 1'b1;
                            cnt_d       = DIV_LD;
                            busy_d      = 1'b1;
                            state_d     = ST_WAIT;
                        end
                        OP_LOA: begin
                            mem_re_d = 1'b1;
                            cnt_d    = MEM_LD;
                            busy_d   = 1'b1;
                            state_d  = ST_WAIT;
                        end
                        OP_LKP: begin
                            lut_re_d = 1'b1;
                            cnt_d    = MEM_LD;
                            busy_d   = 1'b1;
                            state_d  = ST_WAIT;
                        end
                        OP_STR:  mem_we_d = 1'b1;
                        OP_DONE: begin
                            halted_d = 1'b1;
                            state_d  = ST_HALT;
                        end
                        OP_ILL: begin
                            illegal_d = 1'b1;
`ifdef OP_ISSUE_ILLEGAL_TRAP_EN
                            halted_d  = 1'b1;
                            state_d   = ST_HALT;
`endif
                        end
                        default: reg_we_d = 1'b1;
                    endcase
                end
            end
            ST_WAIT: begin
                // The deferred write-back lands in the same cycle fetch is released.
                if (cnt_q == '0) begin
                    reg_we_d = 1'b1;
                    state_d  = ST_DECODE;
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    busy_d = 1'b1;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_DECODE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_DECODE;
            cnt_q       <= '0;
            op_q        <= '0;
            field_q     <= '0;
            ctl_valid_q <= 1'b0;
            alu_start_q <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            lut_re_q    <= 1'b0;
            reg_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            field_q     <= field_d;
            ctl_valid_q <= ctl_valid_d;
            alu_start_q <= alu_start_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            lut_re_q    <= lut_re_d;
            reg_we_q    <= reg_we_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
        end
    end

    assign inst_ready = (state_q == ST_DECODE);
    assign op         = op_q;
    assign field      = field_q;
    assign ctl_valid  = ctl_valid_q;
    assign alu_start  = alu_start_q;
    assign mem_re     = mem_re_q;
    assign mem_we     = mem_we_q;
    assign lut_re     = lut_re_q;
    assign reg_we     = reg_we_q;
    assign busy       = busy_q;
    assign halted     = halted_q;
    assign illegal    = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_op_issue_ctrl.sv
`default_nettype none
// ============================================================================
// tb_op_issue_ctrl : scoreboard bench for op_issue_ctrl (default latencies)
// Revision 1.0
// ============================================================================
module tb_op_issue_ctrl;

    localparam logic [3:0] C_SUB = 4'd0,  C_ADD = 4'd1,  C_DIV = 4'd2,  C_MUL = 4'd3;
    localparam logic [3:0] C_XOR = 4'd4,  C_LOA = 4'd11, C_STR = 4'd12, C_DONE = 4'd13;
    localparam logic [3:0] C_LKP = 4'd14, C_ILL = 4'd15;

    logic       CLK = 1'b0;
    logic       Reset_n;
    logic [8:0] inst;
    logic       inst_valid;
    logic       inst_ready, ctl_valid, alu_start, mem_re, mem_we, lut_re, reg_we;
    logic       busy, halted, illegal;
    logic [3:0] op;
    logic [4:0] field;

    int n_checks = 0;
    int n_fail   = 0;

    logic [13:0] stim_q[$];
    logic [18:0] exp_q[$];

    always #5 CLK = ~CLK;

    op_issue_ctrl dut (
        .CLK(CLK), .Reset_n(Reset_n), .inst(inst), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .op(op), .field(field), .ctl_valid(ctl_valid),
        .alu_start(alu_start), .mem_re(mem_re), .mem_we(mem_we), .lut_re(lut_re),
        .reg_we(reg_we), .busy(busy), .halted(halted), .illegal(illegal)
    );

    wire logic [18:0] obs = {inst_ready, busy, halted, illegal, ctl_valid, alu_start,
                             mem_re, mem_we, lut_re, reg_we, op, field};

    // Field order: rdy busy halt ill ctl alu mre mwe lre rwe op field
    function automatic logic [18:0] ex(input logic rdy, input logic bsy, input logic hlt,
                                       input logic ill, input logic ctl, input logic alu,
                                       input logic mre, input logic mwe, input logic lre,
                                       input logic rwe, input logic [3:0] o, input logic [4:0] f);
        return {rdy, bsy, hlt, ill, ctl, alu, mre, mwe, lre, rwe, o, f};
    endfunction

    // Queue one cycle of stimulus with the outputs expected right after its clock edge.
    task automatic drive(input logic v, input logic [3:0] o, input logic [4:0] f,
                         input logic [18:0] e);
        stim_q.push_back({3'b000, v, o, f});
        exp_q.push_back(e);
    endtask

    task automatic apply();
        logic [13:0] s;
        s = stim_q.pop_front();
        inst_valid = s[9];
        inst       = s[8:0];
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [18:0] e;
        Reset_n    = 1'b1;
        inst_valid = 1'b1;
        inst       = {C_ADD, 5'd3};
        #2 Reset_n = 1'b0;
        #1;
        e = ex(1,0,0,0, 0,0,0,0,0,0, 4'd0, 5'd0);
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_async got=%h exp=%h", obs, e); end
        repeat (2) @(posedge CLK);
        #1;
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_hold got=%h exp=%h", obs, e); end
        Reset_n    = 1'b1;
        inst_valid = 1'b0;
    endtask

    task automatic test_single();
        logic [18:0] e;
        int k = 0;
        drive(1, C_ADD, 5'd3, ex(1,0,0,0, 1,0,0,0,0,1, C_ADD, 5'd3));
        drive(0, C_ADD, 5'd0, ex(1,0,0,0, 0,0,0,0,0,0, C_ADD, 5'd3));
        while (exp_q.size() > 0) begin
            apply();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL single cyc=%0d got=%h exp=%h", k, obs, e); end
            k++;
        end
    endtask

    task automatic test_back_to_back();
        logic [18:0] e;
        int k = 0;
        drive(1, C_SUB, 5'd5, ex(1,0,0,0, 1,0,0,0,0,1, C_SUB, 5'd5));
        drive(1, C_XOR, 5'd7, ex(1,0,0,0, 1,0,0,0,0,1, C_XOR, 5'd7));
        drive(1, C_STR, 5'd9, ex(1,0,0,0, 1,0,0,1,0,0, C_STR, 5'd9));
        drive(0, C_SUB, 5'd0, ex(1,0,0,0, 0,0,0,0,0,0, C_STR, 5'd9));
        while (exp_q.size() > 0) begin
            apply();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL b2b cyc=%0d got=%h exp=%h", k, obs, e); end
            k++;
        end
    endtask

    task automatic test_div();
        logic [18:0] e;
        int k = 0;
        drive(1, C_DIV, 5'd2, ex(0,1,0,0, 1,1,0,0,0,0, C_DIV, 5'd2));
        for (int i = 0; i < 6; i++)
            drive(1, C_ADD, 5'd1, ex(0,1,0,0, 0,0,0,0,0,0, C_DIV, 5'd2));
        drive(1, C_ADD, 5'd1, ex(1,0,0,0, 0,0,0,0,0,1, C_DIV, 5'd2));
        drive(1, C_ADD, 5'd1, ex(1,0,0,0, 1,0,0,0,0,1, C_ADD, 5'd1));
        drive(0, C_ADD, 5'd0, ex(1,0,0,0, 0,0,0,0,0,0, C_ADD, 5'd1));
        while (exp_q.size() > 0) begin
            apply();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL div cyc=%0d got=%h exp=%h", k, obs, e); end
            k++;
        end
    endtask

    task automatic test_loa_lookup();
        logic [18:0] e;
        int k = 0;
        drive(1, C_LOA, 5'd4, ex(0,1,0,0, 1,0,1,0,0,0, C_LOA, 5'd4));
        drive(1, C_LKP, 5'd6, ex(1,0,0,0, 0,0,0,0,0,1, C_LOA, 5'd4));
        drive(1, C_LKP, 5'd6, ex(0,1,0,0, 1,0,0,0,1,0, C_LKP, 5'd6));
        drive(0, C_ADD, 5'd0, ex(1,0,0,0, 0,0,0,0,0,1, C_LKP, 5'd6));
        drive(0, C_ADD, 5'd0, ex(1,0,0,0, 0,0,0,0,0,0, C_LKP, 5'd6));
        while (exp_q.size() > 0) begin
            apply();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL loa_lkp cyc=%0d got=%h exp=%h", k, obs, e); end
            k++;
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [18:0] e;
        int k = 0;
        drive(1, C_MUL, 5'd8, ex(0,1,0,0, 1,1,0,0,0,0, C_MUL, 5'd8));
        drive(0, C_ADD, 5'd0, ex(0,1,0,0, 0,0,0,0,0,0, C_MUL, 5'd8));
        drive(0, C_ADD, 5'd0, ex(0,1,0,0, 0,0,0,0,0,0, C_MUL, 5'd8));
        while (exp_q.size() > 0) begin
            apply();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL mul cyc=%0d got=%h exp=%h", k, obs, e); end
            k++;
        end
        // Now in cycle T+3 of the MUL.
        Reset_n = 1'b0;
        #1;
        e = ex(1,0,0,0, 0,0,0,0,0,0, 4'd0, 5'd0);
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL mul_rst_async got=%h exp=%h", obs, e); end
        @(posedge CLK);
        #1;
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL mul_rst_nowe got=%h exp=%h", obs, e); end
        Reset_n = 1'b1;
        k = 0;
        drive(0, C_ADD, 5'd0, ex(1,0,0,0, 0,0,0,0,0,0, 4'd0, 5'd0));
        drive(1, C_ADD, 5'd1, ex(1,0,0,0, 1,0,0,0,0,1, C_ADD, 5'd1));
        while (exp_q.size() > 0) begin
            apply();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL mul_after cyc=%0d got=%h exp=%h", k, obs, e); end
            k++;
        end
    endtask

    task automatic test_illegal();
        logic [18:0] e;
        int k = 0;
`ifdef OP_ISSUE_ILLEGAL_TRAP_EN
        drive(1, C_ILL, 5'd1, ex(0,0,1,1, 1,0,0,0,0,0, C_ILL, 5'd1));
        drive(1, C_ADD, 5'd2, ex(0,0,1,1, 0,0,0,0,0,0, C_ILL, 5'd1));
        drive(1, C_ADD, 5'd2, ex(0,0,1,1, 0,0,0,0,0,0, C_ILL, 5'd1));
`else
        drive(1, C_ILL, 5'd1, ex(1,0,0,1, 1,0,0,0,0,0, C_ILL, 5'd1));
        drive(1, C_ADD, 5'd2, ex(1,0,0,1, 1,0,0,0,0,1, C_ADD, 5'd2));
        drive(0, C_ADD, 5'd0, ex(1,0,0,1, 0,0,0,0,0,0, C_ADD, 5'd2));
`endif
        while (exp_q.size() > 0) begin
            apply();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL illegal cyc=%0d got=%h exp=%h", k, obs, e); end
            k++;
        end
        Reset_n = 1'b0;
        #1;
        e = ex(1,0,0,0, 0,0,0,0,0,0, 4'd0, 5'd0);
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL illegal_rst got=%h exp=%h", obs, e); end
        @(posedge CLK);
        #1;
        Reset_n = 1'b1;
    endtask

    task automatic test_done();
        logic [18:0] e;
        int k = 0;
        drive(1, C_DONE, 5'd0, ex(0,0,1,0, 1,0,0,0,0,0, C_DONE, 5'd0));
        for (int i = 0; i < 4; i++)
            drive(1, C_ADD, 5'd3, ex(0,0,1,0, 0,0,0,0,0,0, C_DONE, 5'd0));
        while (exp_q.size() > 0) begin
            apply();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL done cyc=%0d got=%h exp=%h", k, obs, e); end
            k++;
        end
        Reset_n = 1'b0;
        #1;
        e = ex(1,0,0,0, 0,0,0,0,0,0, 4'd0, 5'd0);
        n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL done_rst got=%h exp=%h", obs, e); end
        @(posedge CLK);
        #1;
        Reset_n    = 1'b1;
        inst_valid = 1'b0;
    endtask

    initial begin
        inst_valid = 1'b0;
        inst       = '0;
        Reset_n    = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_div();
        test_loa_lookup();
        test_reset_mid_mul();
        test_illegal();
        test_done();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
